conware_feeder: RTL and testbench
=================================

CONWARE_FEEDER -- requirements
Module: conware_feeder

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, pixel word width.
REQ-002 SHALL have parameter WIDTH, default 4, board columns.
REQ-003 SHALL have parameter HEIGHT, default 1, board rows; N = WIDTH*HEIGHT cells.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset; one clock, asynchronous, active-low.
REQ-006 SHALL have ports alive_color, dead_color  input  DWIDTH  pixel encodings.
REQ-007 SHALL have port seed_state  input  N  initial board, bit i = cell i.
REQ-008 SHALL have port seed_load  input  1  in IDLE, copy seed_state into board register.
REQ-009 SHALL have port generations  input  16  generations to run, sampled at start.
REQ-010 SHALL have port start  input  1  single-cycle run request.
REQ-011 SHALL have ports M_AXIS_TVALID/TREADY/TDATA[DWIDTH]/TLAST  out/in/out/out  pixel stream to the game-of-life core.
REQ-012 SHALL have ports S_AXIS_TVALID/TREADY/TDATA[DWIDTH]/TLAST  in/out/in/in  result stream from the core.
REQ-013 SHALL have ports board_state  output  N  current board; gen_count  output  16  completed generations.
REQ-014 SHALL have ports busy  output  1  not IDLE; done  output  1  one-cycle pulse at run end; err  output  1  sticky protocol error.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, RECV, DONE.
REQ-016 IDLE: start=1 with generations>0 -> SEND, latch generations, clear gen_count and err.
REQ-017 start=1 with generations=0 -> DONE directly, no stream traffic, gen_count=0.
REQ-018 start while busy SHALL be ignored; seed_load outside IDLE SHALL be ignored; seed_load and start in the same cycle: load first, run on loaded seed.
REQ-019 SEND: beat k (k=0..N-1) TDATA = board_state[k] ? alive_color : dead_color; TLAST=1 only on k=N-1.
REQ-020 M_AXIS_TVALID SHALL stay high and TDATA/TLAST stable until TREADY; beat advances only on TVALID&&TREADY.
REQ-021 Handshake of beat N-1 SHALL move SEND -> RECV next cycle; M_AXIS_TVALID low outside SEND.
REQ-022 RECV: S_AXIS_TREADY=1; other states 0. Beat k SHALL write next-board bit k = (TDATA == alive_color).
REQ-023 Received TLAST=1 on k<N-1, or TLAST=0 on k=N-1, SHALL set err; frame still ends after exactly N beats.
REQ-024 After beat N-1: board_state <= next-board, gen_count += 1; if gen_count+1 == latched generations -> DONE, else -> SEND.
REQ-025 DONE SHALL assert done for one cycle, then -> IDLE.
REQ-026 Beat counters SHALL be ceil(log2(N)) bits min 1; wrap to 0 at frame end. gen_count SHALL not exceed latched value.
REQ-027 board_state SHALL change only at frame completion or seed_load, never mid-frame.

Reset
REQ-028 rstn low SHALL immediately force IDLE, board_state=0, gen_count=0, counters=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, busy=0, done=0, err=0.
REQ-029 Reset mid-frame SHALL abandon the frame; no partial board update.

Configuration
REQ-030 Macro CONWARE_FEEDER_COLOR_CHECK_EN defined: received TDATA matching neither alive_color nor dead_color SHALL set err and be taken as dead.
REQ-031 Macro undefined: any non-alive pixel is dead silently; err set only per REQ-023.

Verification
REQ-032 WIDTH=4, seed 4'b0110, generations=1, TREADY always 1 -> 4 beats alive/dead per bit, TLAST on beat 3; echo 4'b1001 -> board_state=4'b1001, gen_count=1, done pulse.
REQ-033 M_AXIS_TREADY toggling 1,0,0,1 -> TDATA/TLAST held stable during stalls, exactly 4 handshakes, no beat lost or repeated.
REQ-034 generations=3 with loopback responder -> three SEND/RECV cycles, gen_count 1,2,3, single done after third frame.
REQ-035 Result TLAST on beat 1 of 4 -> err=1, still 4 beats consumed, board updated; err clears at next start.
REQ-036 rstn low during RECV beat 2 -> all outputs reset values same cycle, board_state=0; generations=0 start -> done next cycle, zero handshakes.
REQ-037 COLOR_CHECK_EN defined, result pixel 32'h12345678 -> err=1, cell dead; undefined -> err=0, cell dead.

Source files
------------

// File: rtl/conware_feeder.sv
// conware_feeder
// Streams a Game-of-Life board to an external core one pixel per cell, collects
// the core's result frame and folds it back into the board register, repeating
// for a requested number of generations.
//
// Optional build macro: CONWARE_FEEDER_COLOR_CHECK_EN
//   defined   -> a result pixel matching neither colour sets err and is taken as dead
//   undefined -> any non-alive pixel is silently dead
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   alive_color, dead_color   pixel encodings used on both streams
//   seed_state, seed_load     initial board, loaded while idle
//   generations, start        run length (sampled at start), run request
//   M_AXIS_*                  outgoing pixel stream (board -> core)
//   S_AXIS_*                  incoming result stream (core -> board)
//   board_state, gen_count    current board, completed generations
//   busy, done, err           not idle, end-of-run pulse, sticky protocol error
module conware_feeder #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DWIDTH-1:0]         alive_color,
  input  logic [DWIDTH-1:0]         dead_color,
  input  logic [WIDTH*HEIGHT-1:0]   seed_state,
  input  logic                      seed_load,
  input  logic [15:0]               generations,
  input  logic                      start,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [DWIDTH-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic [DWIDTH-1:0]         S_AXIS_TDATA,
  input  logic                      S_AXIS_TLAST,
  output logic [WIDTH*HEIGHT-1:0]   board_state,
  output logic [15:0]               gen_count,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [N-1:0]      board_q, board_d;
  logic [N-1:0]      next_q, next_d;
  logic [15:0]       gen_q, gen_d;
  logic [15:0]       lim_q, lim_d;
  logic [CW-1:0]     sbeat_q, sbeat_d;
  logic [CW-1:0]     rbeat_q, rbeat_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              mvalid_q, mvalid_d;
  logic [DWIDTH-1:0] mdata_q, mdata_d;
  logic              mlast_q, mlast_d;
  logic              sready_q, sready_d;

  logic              m_fire_s, s_fire_s;
  logic              rx_alive_s, rx_last_bad_s, rx_color_bad_s;
  logic [CW-1:0]     sbeat_nxt_s;
  logic [N-1:0]      next_full_s;
  logic [15:0]       gen_inc_s;

  assign m_fire_s      = mvalid_q & M_AXIS_TREADY;
  assign s_fire_s      = sready_q & S_AXIS_TVALID;
  assign rx_alive_s    = (S_AXIS_TDATA == alive_color);
  // TLAST must be high exactly on the final beat of the frame.
  assign rx_last_bad_s = (S_AXIS_TLAST != (rbeat_q == LAST_BEAT));
  assign sbeat_nxt_s   = sbeat_q + {{(CW-1){1'b0}}, 1'b1};
  assign gen_inc_s     = gen_q + 16'd1;

`ifdef CONWARE_FEEDER_COLOR_CHECK_EN
  assign rx_color_bad_s = ~rx_alive_s & (S_AXIS_TDATA != dead_color);
`else
  assign rx_color_bad_s = 1'b0;
`endif

  // Result frame accumulator with the current beat merged in, so the last beat
  // can commit the whole frame in the same cycle.
  always_comb begin
    next_full_s          = next_q;
    next_full_s[rbeat_q] = rx_alive_s;
  end

  // Next-state logic for the run controller and both stream ports.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    next_d   = next_q;
    gen_d    = gen_q;
    lim_d    = lim_q;
    sbeat_d  = sbeat_q;
    rbeat_d  = rbeat_q;
    err_d    = err_q;
    done_d   = 1'b0;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    sready_d = sready_q;
    case (state_q)
      S_IDLE: begin
        // Seed lands first so a same-cycle start streams the new board.
        if (seed_load) begin
          board_d = seed_state;
        end else begin
          board_d = board_q;
        end
        if (start) begin
          gen_d = 16'd0;
          err_d = 1'b0;
          lim_d = generations;
          if (generations != 16'd0) begin
            state_d  = S_SEND;
            sbeat_d  = {CW{1'b0}};
            mvalid_d = 1'b1;
            mdata_d  = board_d[0] ? alive_color : dead_color;
            mlast_d  = (LAST_BEAT == {CW{1'b0}});
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (m_fire_s) begin
          if (sbeat_q == LAST_BEAT) begin
            state_d  = S_RECV;
            sbeat_d  = {CW{1'b0}};
            rbeat_d  = {CW{1'b0}};
            mvalid_d = 1'b0;
            mdata_d  = {DWIDTH{1'b0}};
            mlast_d  = 1'b0;
            sready_d = 1'b1;
          end else begin
            sbeat_d = sbeat_nxt_s;
            mdata_d = board_q[sbeat_nxt_s] ? alive_color : dead_color;
            mlast_d = (sbeat_nxt_s == LAST_BEAT);
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_RECV: begin
        if (s_fire_s) begin
          err_d  = err_q | rx_last_bad_s | rx_color_bad_s;
          next_d = next_full_s;
          // The frame closes on beat count alone, whatever TLAST said.
          if (rbeat_q == LAST_BEAT) begin
            rbeat_d  = {CW{1'b0}};
            board_d  = next_full_s;
            gen_d    = gen_inc_s;
            sready_d = 1'b0;
            if (gen_inc_s == lim_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d  = S_SEND;
              sbeat_d  = {CW{1'b0}};
              mvalid_d = 1'b1;
              mdata_d  = next_full_s[0] ? alive_color : dead_color;
              mlast_d  = (LAST_BEAT == {CW{1'b0}});
            end
          end else begin
            rbeat_d = rbeat_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mvalid_d = 1'b0;
        mdata_d  = {DWIDTH{1'b0}};
        mlast_d  = 1'b0;
        sready_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      board_q  <= {N{1'b0}};
      next_q   <= {N{1'b0}};
      gen_q    <= 16'd0;
      lim_q    <= 16'd0;
      sbeat_q  <= {CW{1'b0}};
      rbeat_q  <= {CW{1'b0}};
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= {DWIDTH{1'b0}};
      mlast_q  <= 1'b0;
      sready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      next_q   <= next_d;
      gen_q    <= gen_d;
      lim_q    <= lim_d;
      sbeat_q  <= sbeat_d;
      rbeat_q  <= rbeat_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
      sready_q <= sready_d;
    end
  end

  assign M_AXIS_TVALID = mvalid_q;
  assign M_AXIS_TDATA  = mdata_q;
  assign M_AXIS_TLAST  = mlast_q;
  assign S_AXIS_TREADY = sready_q;
  assign board_state   = board_q;
  assign gen_count     = gen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_conware_feeder.sv
module tb_conware_feeder;
  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] alive_color = '0, dead_color = '0;
  logic [N-1:0]  seed_state = '0;
  logic          seed_load = 1'b0;
  logic [15:0]   generations = 16'd0;
  logic          start = 1'b0;
  logic          M_AXIS_TVALID, M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b0;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          S_AXIS_TVALID = 1'b0, S_AXIS_TLAST = 1'b0;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic [N-1:0]  board_state;
  logic [15:0]   gen_count;
  logic          busy, done, err;

  conware_feeder #(.DWIDTH(DW), .WIDTH(4), .HEIGHT(1)) dut (
    .clk(clk), .rstn(rstn), .alive_color(alive_color), .dead_color(dead_color),
    .seed_state(seed_state), .seed_load(seed_load), .generations(generations),
    .start(start),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .board_state(board_state), .gen_count(gen_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state of the run, maintained from the rules, not the RTL.
  logic [N-1:0] exp_board = '0;
  logic [15:0]  exp_gen = 16'd0;
  logic         exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input logic b);
    return b ? alive_color : dead_color;
  endfunction

  task automatic start_run(input logic [15:0] g);
    generations = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_gen = 16'd0;
    exp_err = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    chk("gen_cleared", gen_count, 0);
  endtask

  // Sink the outgoing frame. mode 0: always ready, 1: ready 1,0,0,1, 2: random.
  task automatic m_frame(input int mode);
    int k = 0;
    int cyc = 0;
    logic rdy;
    logic held = 1'b0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    while (k < N && cyc < 200) begin
      @(negedge clk);
      if (M_AXIS_TVALID) begin
        if (held) begin
          chk("m_hold_data", M_AXIS_TDATA, hd);
          chk("m_hold_last", M_AXIS_TLAST, hl);
        end
        chk("m_data", M_AXIS_TDATA, pix(exp_board[k]));
        chk("m_last", M_AXIS_TLAST, (k == N - 1));
      end
      chk("board_stable_send", board_state, exp_board);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      M_AXIS_TREADY = rdy;
      if (M_AXIS_TVALID && rdy) begin
        k++;
        held = 1'b0;
      end else if (M_AXIS_TVALID) begin
        held = 1'b1;
        hd = M_AXIS_TDATA;
        hl = M_AXIS_TLAST;
      end
    end
    chk("m_beats", k, N);
  endtask

  // Drive a result frame. bad_k flips TLAST on that beat, odd_k sends a
  // foreign pixel, abort_k pulls reset before that beat (-1 disables each).
  task automatic s_frame(input logic [N-1:0] res, input int bad_k, input int odd_k,
                         input int abort_k);
    int k = 0;
    int cyc = 0;
    @(negedge clk);
    M_AXIS_TREADY = 1'b0;
    chk("recv_no_mvalid", M_AXIS_TVALID, 0);
    chk("recv_tready", S_AXIS_TREADY, 1);
    while (k < N && cyc < 200) begin
      chk("board_stable_recv", board_state, exp_board);
      if (k == abort_k) begin
        rstn = 1'b0;
        #1;
        chk("rst_mvalid", M_AXIS_TVALID, 0);
        chk("rst_mdata", M_AXIS_TDATA, 0);
        chk("rst_mlast", M_AXIS_TLAST, 0);
        chk("rst_sready", S_AXIS_TREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_board", board_state, 0);
        chk("rst_gen", gen_count, 0);
        break;
      end
      if (S_AXIS_TREADY && ($urandom_range(0, 3) != 0)) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = (k == odd_k) ? 32'h1234_5678 : pix(res[k]);
        S_AXIS_TLAST  = (k == N - 1) ^ (k == bad_k);
        k++;
      end else begin
        S_AXIS_TVALID = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    if (abort_k < 0) chk("s_beats", k, N);
  endtask

  task automatic gen_end(input logic last);
    chk("board_after_frame", board_state, exp_board);
    chk("gen_after_frame", gen_count, exp_gen);
    chk("err_after_frame", err, exp_err);
    chk("done_after_frame", done, last);
    if (last) begin
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  logic [N-1:0] res;

  initial begin
    alive_color = $urandom | 32'h8000_0000;
    dead_color  = $urandom & 32'h7FFF_FFFF;
    if (dead_color == 32'h1234_5678) dead_color = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_board", board_state, 0);
    chk("reset_mvalid", M_AXIS_TVALID, 0);
    chk("reset_mdata", M_AXIS_TDATA, 0);
    chk("reset_sready", S_AXIS_TREADY, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Seed 0110, one generation, echo 1001
    seed_state = 4'b0110;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    exp_board = 4'b0110;
    chk("seed_loaded", board_state, exp_board);
    start_run(16'd1);
    m_frame(0);
    s_frame(4'b1001, -1, -1, -1);
    exp_board = 4'b1001;
    exp_gen = 16'd1;
    gen_end(1'b1);

    // Stalling sink 1,0,0,1
    start_run(16'd1);
    m_frame(1);
    res = 4'($urandom);
    s_frame(res, -1, -1, -1);
    exp_board = res;
    exp_gen = 16'd1;
    gen_end(1'b1);

    // Three generations; start and seed_load while busy are ignored
    start_run(16'd3);
    seed_state = ~exp_board;
    seed_load = 1'b1;
    start = 1'b1;
    generations = 16'd0;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_frame(2);
      res = (i == 0) ? exp_board : 4'($urandom);
      s_frame(res, -1, -1, -1);
      exp_board = res;
      exp_gen = 16'(i + 1);
      gen_end(i == 2);
    end

    // Early TLAST on result beat 1
    start_run(16'd1);
    m_frame(2);
    res = 4'($urandom);
    s_frame(res, 1, -1, -1);
    exp_board = res;
    exp_gen = 16'd1;
    exp_err = 1'b1;
    gen_end(1'b1);

    // Seed load and start together; err clears at start
    seed_state = 4'($urandom);
    seed_load = 1'b1;
    start_run(16'd2);
    seed_load = 1'b0;
    exp_board = seed_state;
    for (int i = 0; i < 2; i++) begin
      m_frame(2);
      res = 4'($urandom);
      s_frame(res, -1, -1, -1);
      exp_board = res;
      exp_gen = 16'(i + 1);
      gen_end(i == 1);
    end

    // Reset during result beat 2
    start_run(16'd1);
    m_frame(0);
    s_frame(4'($urandom), -1, -1, 2);
    exp_board = '0;
    exp_gen = 16'd0;
    exp_err = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Zero generations: immediate done, no stream traffic
    generations = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_gen_done", done, 1);
    chk("zero_gen_count", gen_count, 0);
    chk("zero_gen_mvalid", M_AXIS_TVALID, 0);
    @(negedge clk);
    chk("zero_gen_done_end", done, 0);
    chk("zero_gen_idle", busy, 0);
    chk("zero_gen_mvalid2", M_AXIS_TVALID, 0);

    // Foreign result pixel on beat 2
    seed_state = 4'($urandom);
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    exp_board = seed_state;
    start_run(16'd1);
    m_frame(0);
    s_frame(4'b1111, -1, 2, -1);
    exp_board = 4'b1011;
    exp_gen = 16'd1;
`ifdef CONWARE_FEEDER_COLOR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    gen_end(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
